tensor_slice_int8_driver: RTL and testbench
===========================================

// Module: tensor_slice_int8_driver
// PURPOSE
//  Initiator-side sequencer for one tensor_slice_int8 instance. Accepts (A row, B column) operand
//  pairs on a valid/ready stream, issues each as one start_mat_mul job, waits for c_data_available,
//  then returns the 8x16-bit C row on a valid/ready result stream. Sits between the HLS wrapper
//  and the slice. Also owns slice reset sequencing, static config tie-offs and a response watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES   63   WAIT-state cycles allowed before a job is abandoned (range 34..255)
//  RST_HOLD_CYCLES  2    cycles ts_reset stays high after reset_n deasserts (range 1..15)
// PORTS
//  clk                  in   1    single clock for driver and slice
//  reset_n              in   1    asynchronous, active-low reset
//  in_valid / in_ready  in/out 1  operand handshake
//  in_a_data            in   64   A row, lane i = bits [8i+7:8i], signed int8
//  in_b_data            in   64   B column, same packing
//  out_valid / out_ready out/in 1 result handshake
//  out_c_data           out  128  C row, lane i = bits [16i+15:16i]
//  busy                 out  1    state != IDLE or ts_reset high
//  err_timeout          out  1    sticky watchdog flag
//  err_clear            in   1    synchronous clear of err_timeout
//  ts_reset, ts_pe_reset out 1    slice resets (active-high, synchronous at slice)
//  ts_start_mat_mul     out  1    one-cycle job start
//  ts_a_data, ts_b_data out  64   operands to slice
//  ts_c_data_available  in   1    slice result strobe
//  ts_c_data_out        in   128  slice result
//  ts_done_mat_mul      in   1    slice done (monitored by the perf counter only)
//  ts_cfg_*             out  var  static tie-offs (see BEHAVIOUR)
// BEHAVIOUR
//  Reset (reset_n low): state=IDLE; in_ready, out_valid, ts_start_mat_mul, ts_pe_reset, err_timeout = 0;
//   out_c_data, ts_a_data, ts_b_data = 0; ts_reset=1; busy=1. Reset mid-job aborts silently, no output.
//  After release, ts_reset holds for RST_HOLD_CYCLES rising edges, then 0; in_ready stays 0 until then.
//  FSM IDLE->ISSUE->WAIT->OUT->IDLE:
//   IDLE : in_ready=1 (once ts_reset=0). On in_valid&in_ready latch operands into ts_a/b_data -> ISSUE.
//   ISSUE: ts_start_mat_mul=1 for exactly this cycle; wdog counter cleared -> WAIT.
//   WAIT : ts_a/b_data held stable; counter++ per cycle. On ts_c_data_available: capture ts_c_data_out
//          into out_c_data, out_valid=1 -> OUT. If counter==TIMEOUT_CYCLES first: err_timeout<=1,
//          ts_pe_reset=1 for one cycle, drop job, -> IDLE.
//   OUT  : out_valid held with stable data until out_valid&out_ready; then out_valid=0 -> IDLE.
//  Latency: accept at cycle t, start at t+1, slice strobe nominally t+34, out_valid at t+35.
//   The driver does not depend on the exact slice latency, only on the strobe.
//  Throughput: one job in flight at a time; no operand buffering beyond the latch.
//  ts_c_data_available outside WAIT is ignored. Strobe and timeout in the same cycle: strobe wins.
//  err_clear and a new timeout in the same cycle: set wins.
//  Static tie-offs: validity masks = 8'hFF; final_mat_mul_size = 8; a_loc = b_loc = 0;
//   slice_dtype = 0; slice_mode = 0; op = 0; preload = 0; no_rounding = 1;
//   chain a_data_in = b_data_in = 0.
// CONFIGURATION
//  TS_DRV_PERF_EN defined: adds outputs perf_jobs[31:0] (increments on each completed out handshake)
//   and perf_busy[31:0] (increments each cycle in ISSUE/WAIT/OUT). Both wrap at 2^32 and are cleared
//   only by reset_n. A ts_done_mat_mul not coincident with ts_c_data_available also sets err_timeout.
//  Undefined: both ports exist and are driven to constant 0; no done/available cross-check.
// TESTING
//  1. in_a=all 8'h01, in_b lanes=1..8 -> one ts_start pulse; out_c lane i = 8*(i+1)
//     (16'h0008..16'h0040); out_valid at t+35.
//  2. Hold out_ready=0 for 20 cycles in OUT -> out_c_data stable, in_ready=0, no second ts_start;
//     release -> IDLE next cycle.
//  3. Slice stub never strobes -> err_timeout=1 and ts_pe_reset pulses after TIMEOUT_CYCLES=63
//     in WAIT; no out_valid; err_clear clears the flag.
//  4. Drop reset_n during WAIT -> all outputs take reset values asynchronously; ts_reset held
//     2 cycles after release; no stale result emitted.
//  5. 100 back-to-back random jobs with out_ready always 1 -> results match golden
//     (sum a)*b[i] truncated to 16 bits, in order.
//  6. With TS_DRV_PERF_EN: after test 5, perf_jobs=100 and perf_busy=100*35.

Source files
------------

// File: rtl/tensor_slice_int8_driver_if.sv
// rtl/tensor_slice_int8_driver_if.sv - operand and result stream bundle between the HLS wrapper and the slice driver
interface tensor_slice_int8_driver_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_a_data;
  logic [63:0]  in_b_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_c_data;

  // Wrapper side: offers operands, consumes results
  modport master (
    output in_valid, in_a_data, in_b_data, out_ready,
    input  in_ready, out_valid, out_c_data
  );

  // Driver side: accepts operands, offers results
  modport slave (
    input  in_valid, in_a_data, in_b_data, out_ready,
    output in_ready, out_valid, out_c_data
  );
endinterface

// File: rtl/tensor_slice_int8_driver.sv
// rtl/tensor_slice_int8_driver.sv - one-job-at-a-time sequencer for a tensor_slice_int8 (optional TS_DRV_PERF_EN perf counters)
module tensor_slice_int8_driver #(
  parameter int TIMEOUT_CYCLES  = 63,
  parameter int RST_HOLD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  tensor_slice_int8_driver_if.slave  host,
  output logic                       busy,
  output logic                       err_timeout,
  input  logic                       err_clear,
  output logic                       ts_reset,
  output logic                       ts_pe_reset,
  output logic                       ts_start_mat_mul,
  output logic [63:0]                ts_a_data,
  output logic [63:0]                ts_b_data,
  input  logic                       ts_c_data_available,
  input  logic [127:0]               ts_c_data_out,
  input  logic                       ts_done_mat_mul,
  output logic [7:0]                 ts_cfg_validity_a_rows,
  output logic [7:0]                 ts_cfg_validity_a_cols_b_rows,
  output logic [7:0]                 ts_cfg_validity_b_cols,
  output logic [7:0]                 ts_cfg_final_mat_mul_size,
  output logic [7:0]                 ts_cfg_a_loc,
  output logic [7:0]                 ts_cfg_b_loc,
  output logic                       ts_cfg_slice_dtype,
  output logic                       ts_cfg_slice_mode,
  output logic [1:0]                 ts_cfg_op,
  output logic                       ts_cfg_preload,
  output logic                       ts_cfg_no_rounding,
  output logic [63:0]                ts_cfg_a_data_in,
  output logic [63:0]                ts_cfg_b_data_in,
  output logic [31:0]                perf_jobs,
  output logic [31:0]                perf_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t       state_q, state_d;
  logic [63:0]  a_q, a_d, b_q, b_d;
  logic [127:0] c_q, c_d;
  logic [7:0]   wdog_q, wdog_d;
  logic [3:0]   rst_cnt_q;
  logic         ts_reset_q, pe_reset_q, err_q;
  logic         timeout_hit, err_set;

  assign host.in_ready  = (state_q == S_IDLE) && !ts_reset_q;
  assign host.out_valid = (state_q == S_OUT);
  assign host.out_c_data = c_q;
  assign ts_start_mat_mul = (state_q == S_ISSUE);
  assign ts_a_data   = a_q;
  assign ts_b_data   = b_q;
  assign ts_reset    = ts_reset_q;
  assign ts_pe_reset = pe_reset_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != S_IDLE) || ts_reset_q;

  // Static slice configuration: full 8x8 int8 matmul, no chaining, no rounding
  assign ts_cfg_validity_a_rows        = 8'hFF;
  assign ts_cfg_validity_a_cols_b_rows = 8'hFF;
  assign ts_cfg_validity_b_cols        = 8'hFF;
  assign ts_cfg_final_mat_mul_size     = 8'd8;
  assign ts_cfg_a_loc                  = 8'd0;
  assign ts_cfg_b_loc                  = 8'd0;
  assign ts_cfg_slice_dtype            = 1'b0;
  assign ts_cfg_slice_mode             = 1'b0;
  assign ts_cfg_op                     = 2'd0;
  assign ts_cfg_preload                = 1'b0;
  assign ts_cfg_no_rounding            = 1'b1;
  assign ts_cfg_a_data_in              = 64'd0;
  assign ts_cfg_b_data_in              = 64'd0;

  // Job sequencing; a strobe in WAIT beats a watchdog expiry in the same cycle
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    wdog_d      = wdog_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host.in_valid && !ts_reset_q) begin
          a_d     = host.in_a_data;
          b_d     = host.in_b_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ts_c_data_available) begin
          c_d     = ts_c_data_out;
          state_d = S_OUT;
        end else if (wdog_q == 8'(TIMEOUT_CYCLES)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_OUT: begin
        if (host.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TS_DRV_PERF_EN
  // A done without its result strobe means the slice lost a result
  assign err_set = timeout_hit || (ts_done_mat_mul && !ts_c_data_available);
`else
  logic unused_done;
  assign unused_done = ts_done_mat_mul;
  assign err_set     = timeout_hit;
`endif

  // State, operand/result registers, watchdog and error flag (set beats clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      wdog_q     <= '0;
      pe_reset_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      wdog_q     <= wdog_d;
      pe_reset_q <= timeout_hit;
      if (err_set)        err_q <= 1'b1;
      else if (err_clear) err_q <= 1'b0;
    end
  end

  // Keep the slice in reset for a few edges after our own reset releases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_reset_q <= 1'b1;
      rst_cnt_q  <= 4'(RST_HOLD_CYCLES);
    end else if (ts_reset_q) begin
      if (rst_cnt_q <= 4'd1) ts_reset_q <= 1'b0;
      else                   rst_cnt_q  <= rst_cnt_q - 4'd1;
    end
  end

`ifdef TS_DRV_PERF_EN
  logic [31:0] perf_jobs_q, perf_busy_q;
  assign perf_jobs = perf_jobs_q;
  assign perf_busy = perf_busy_q;

  // Completed-result and occupied-cycle counters, free-running and wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_jobs_q <= '0;
      perf_busy_q <= '0;
    end else begin
      if (state_q == S_OUT && host.out_ready) perf_jobs_q <= perf_jobs_q + 32'd1;
      if (state_q != S_IDLE)                  perf_busy_q <= perf_busy_q + 32'd1;
    end
  end
`else
  assign perf_jobs = 32'd0;
  assign perf_busy = 32'd0;
`endif

endmodule

// File: tb/tb_tensor_slice_int8_driver.sv
// tb/tb_tensor_slice_int8_driver.sv - randomized self-checking bench for tensor_slice_int8_driver
module tb_tensor_slice_int8_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_clear = 1'b0;
  logic busy, err_timeout, ts_reset, ts_pe_reset, ts_start_mat_mul;
  logic [63:0]  ts_a_data, ts_b_data;
  logic         stub_avail = 1'b0, spur_avail = 1'b0, stub_done = 1'b0, stub_en = 1'b1;
  logic         ts_c_data_available;
  logic [127:0] ts_c_data_out = '0;
  logic [7:0]   cfg_va, cfg_vab, cfg_vb, cfg_size, cfg_aloc, cfg_bloc;
  logic         cfg_dtype, cfg_mode, cfg_pre, cfg_norm;
  logic [1:0]   cfg_op;
  logic [63:0]  cfg_ain, cfg_bin;
  logic [31:0]  perf_jobs, perf_busy;

  tensor_slice_int8_driver_if bus();

  assign ts_c_data_available = stub_avail | spur_avail;

  tensor_slice_int8_driver dut (
    .clk(clk), .reset_n(reset_n), .host(bus.slave),
    .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear),
    .ts_reset(ts_reset), .ts_pe_reset(ts_pe_reset), .ts_start_mat_mul(ts_start_mat_mul),
    .ts_a_data(ts_a_data), .ts_b_data(ts_b_data),
    .ts_c_data_available(ts_c_data_available), .ts_c_data_out(ts_c_data_out),
    .ts_done_mat_mul(stub_done),
    .ts_cfg_validity_a_rows(cfg_va), .ts_cfg_validity_a_cols_b_rows(cfg_vab),
    .ts_cfg_validity_b_cols(cfg_vb), .ts_cfg_final_mat_mul_size(cfg_size),
    .ts_cfg_a_loc(cfg_aloc), .ts_cfg_b_loc(cfg_bloc), .ts_cfg_slice_dtype(cfg_dtype),
    .ts_cfg_slice_mode(cfg_mode), .ts_cfg_op(cfg_op), .ts_cfg_preload(cfg_pre),
    .ts_cfg_no_rounding(cfg_norm), .ts_cfg_a_data_in(cfg_ain), .ts_cfg_b_data_in(cfg_bin),
    .perf_jobs(perf_jobs), .perf_busy(perf_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out = 0;
  int n_start = 0;
  int acc_cyc = 0;
  int out_rise_cyc = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // C lane i = (sum of signed A lanes) * signed B lane i, kept to 16 bits
  function automatic logic [127:0] golden(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] r;
    int s;
    s = 0;
    for (int j = 0; j < 8; j++) s += int'($signed(a[8*j +: 8]));
    for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(s * int'($signed(b[8*i +: 8])));
    return r;
  endfunction

  // Slice stub: result strobe 33 cycles after the start cycle, garbage on the bus otherwise
  initial begin
    forever begin
      @(negedge clk);
      if (ts_start_mat_mul && stub_en) begin
        repeat (33) @(posedge clk);
        #1;
        stub_avail = 1'b1;
        stub_done = 1'b1;
        ts_c_data_out = golden(ts_a_data, ts_b_data);
        @(posedge clk);
        #1;
        stub_avail = 1'b0;
        stub_done = 1'b0;
        ts_c_data_out = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  end

  // Result monitor: every out handshake must match the oldest expected row
  initial begin
    logic ov_prev;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ts_start_mat_mul) n_start++;
      if (bus.out_valid && !ov_prev) out_rise_cyc = cyc;
      ov_prev = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        last_c = bus.out_c_data;
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_out", 1'b1, 1'b0);
        else chk("c_row", bus.out_c_data, exp_q.pop_front());
      end
    end
  end

  task automatic drive_phase();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input bit push);
    int n;
    bus.in_a_data = a;
    bus.in_b_data = b;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 300) begin
        chk("in_ready_timeout", 1'b0, 1'b1);
        break;
      end
    end
    acc_cyc = cyc;
    if (push) exp_q.push_back(golden(a, b));
    drive_phase();
    bus.in_valid = 1'b0;
    bus.in_a_data = {$urandom(), $urandom()};
    bus.in_b_data = {$urandom(), $urandom()};
  endtask

  task automatic wait_outs(input int target, input int budget);
    int n;
    n = 0;
    while (n_out < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("out_count", 128'(n_out >= target), 128'd1);
    drive_phase();
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    @(negedge clk);
    chk("ts_reset_hold0", ts_reset, 1'b1);
    @(negedge clk);
    chk("ts_reset_hold1", ts_reset, 1'b1);
    chk("in_ready_in_hold", bus.in_ready, 1'b0);
    @(negedge clk);
    chk("ts_reset_released", ts_reset, 1'b0);
    chk("in_ready_idle", bus.in_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
    drive_phase();
  endtask

  initial begin
    logic [127:0] c0;
    int bad, st0, n, seen;
    bus.in_valid = 1'b0;
    bus.in_a_data = '0;
    bus.in_b_data = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_start", ts_start_mat_mul, 1'b0);
    chk("rst_pe_reset", ts_pe_reset, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_out_c", bus.out_c_data, 128'd0);
    chk("rst_ts_a", ts_a_data, 64'd0);
    chk("rst_ts_reset", ts_reset, 1'b1);
    chk("rst_busy", busy, 1'b1);
    chk("cfg_masks", {cfg_va, cfg_vab, cfg_vb}, 24'hFFFFFF);
    chk("cfg_size", cfg_size, 8'd8);
    chk("cfg_misc", {cfg_aloc, cfg_bloc, cfg_dtype, cfg_mode, cfg_op, cfg_pre, cfg_norm}, 22'd1);
    chk("cfg_chain", {cfg_ain, cfg_bin}, 128'd0);
    drive_phase();
    release_reset();

    // Test 1: unit A row, B lanes 1..8
    st0 = n_start;
    send({8{8'h01}}, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    wait_outs(1, 100);
    chk("t1_c_row", last_c, 128'h0040_0038_0030_0028_0020_0018_0010_0008);
    chk("t1_latency", 128'(out_rise_cyc - acc_cyc), 128'd35);
    chk("t1_starts", 128'(n_start - st0), 128'd1);

    // Test 2: result held under back-pressure
    bus.out_ready = 1'b0;
    st0 = n_start;
    send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t2_out_valid", bus.out_valid, 1'b1);
    c0 = bus.out_c_data;
    bad = 0;
    drive_phase();
    bus.in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_c_data !== c0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    chk("t2_hold_stable", 128'(bad), 128'd0);
    chk("t2_no_restart", 128'(n_start - st0), 128'd1);
    drive_phase();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_idle_after", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("t2_out_count", 128'(n_out), 128'd2);
    drive_phase();

    // Test 3: watchdog
    stub_en = 1'b0;
    send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0);
    n = 0;
    while (!ts_pe_reset && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t3_pe_reset_time", 128'(cyc - acc_cyc), 128'd66);
    chk("t3_err_set", err_timeout, 1'b1);
    @(negedge clk);
    chk("t3_pe_reset_pulse", ts_pe_reset, 1'b0);
    chk("t3_idle", bus.in_ready, 1'b1);
    drive_phase();
    stub_en = 1'b1;
    spur_avail = 1'b1;
    drive_phase();
    spur_avail = 1'b0;
    @(negedge clk);
    chk("t3_spurious_ignored", {busy, bus.out_valid}, 2'b00);
    chk("t3_err_sticky", err_timeout, 1'b1);
    drive_phase();
    err_clear = 1'b1;
    drive_phase();
    err_clear = 1'b0;
    @(negedge clk);
    chk("t3_err_cleared", err_timeout, 1'b0);
    drive_phase();

    // Test 4: asynchronous reset during WAIT
    send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
    repeat (8) drive_phase();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_async_outs", {bus.in_ready, bus.out_valid, ts_start_mat_mul, ts_reset, busy}, 5'b00011);
    chk("t4_async_ops", {ts_a_data, ts_b_data}, 128'd0);
    exp_q.delete();
    seen = n_out;
    repeat (3) drive_phase();
    release_reset();
    repeat (40) drive_phase();
    chk("t4_no_stale", 128'(n_out - seen), 128'd0);

    // Test 5: back-to-back random jobs
    seen = n_out;
    for (int k = 0; k < 100; k++)
      send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
    wait_outs(seen + 100, 200);
    chk("t5_queue_empty", 128'(exp_q.size()), 128'd0);
    chk("t5_no_err", err_timeout, 1'b0);

`ifdef TS_DRV_PERF_EN
    chk("t6_perf_jobs", perf_jobs, 32'd100);
    chk("t6_perf_busy", perf_busy, 32'd3500);
`else
    chk("perf_jobs_tied", perf_jobs, 32'd0);
    chk("perf_busy_tied", perf_busy, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
